dma_job_sched: RTL and testbench

- Descriptor-driven scheduler that sits between the CSR front end and the single-copy DMA engine (the engine takes rd_addr/wr_addr/len plus a begin strobe).
- Queues copy jobs, splits each job into chunks of at most MAX_CHUNK cache lines, and starts the engine one chunk at a time.
- After each chunk completes, waits for MPF outstanding-request drain (c0NotEmpty/c1NotEmpty), then issues the next chunk.
- Keeps job and chunk counters plus sticky error flags for the CSR read path.

---
 rtl/dma_job_sched.sv | 216 +++++++++++++++++++++
 tb/tb_dma_job_sched.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_job_sched.sv
// dma_job_sched
//   Copy-job scheduler between the CSR front end and a single-copy DMA engine.
//   Descriptors (src, dst, len in cache lines) are queued in a small FIFO. Each
//   job is split into chunks of at most MAX_CHUNK lines. The engine is started
//   one chunk at a time. After each chunk the scheduler waits for the MPF
//   request channels to drain before it issues the next chunk.
//
// Ports
//   clk, reset              single clock, asynchronous active-high reset
//   desc_valid/desc_ready   descriptor handshake; desc_src/desc_dst/desc_len payload
//   dma_rd_addr/wr_addr/len chunk parameters, held between starts
//   dma_start               one-cycle begin strobe; dma_done one-cycle completion pulse
//   c0NotEmpty/c1NotEmpty   MPF reads / unacknowledged writes still in flight
//   clr_stats               zeroes counters and sticky error flags
//   idle, queue_level       status: FSM idle with an empty queue; queued descriptor count
//   jobs_done/chunks_issued wrapping 32-bit statistics
//   err_zero_len/err_timeout sticky error flags
module dma_job_sched #(
  parameter int ADDR_W         = 42,
  parameter int LEN_W          = 32,
  parameter int FIFO_DEPTH     = 4,
  parameter int MAX_CHUNK      = 256,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        desc_valid,
  output logic                        desc_ready,
  input  logic [ADDR_W-1:0]           desc_src,
  input  logic [ADDR_W-1:0]           desc_dst,
  input  logic [LEN_W-1:0]            desc_len,
  output logic [ADDR_W-1:0]           dma_rd_addr,
  output logic [ADDR_W-1:0]           dma_wr_addr,
  output logic [LEN_W-1:0]            dma_len,
  output logic                        dma_start,
  input  logic                        dma_done,
  input  logic                        c0NotEmpty,
  input  logic                        c1NotEmpty,
  input  logic                        clr_stats,
  output logic                        idle,
  output logic [$clog2(FIFO_DEPTH):0] queue_level,
  output logic [31:0]                 jobs_done,
  output logic [31:0]                 chunks_issued,
  output logic                        err_zero_len,
  output logic                        err_timeout
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [LEN_W-1:0]  MAX_CHUNK_L = LEN_W'(MAX_CHUNK);
  localparam logic [WD_W-1:0]   WD_LIMIT    = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [PTR_W:0]    FULL_LEVEL  = (PTR_W+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ISSUE, S_WAIT_DONE, S_DRAIN} state_e;

  // Descriptor queue
  logic [ADDR_W-1:0] fifo_src_q [FIFO_DEPTH];
  logic [ADDR_W-1:0] fifo_dst_q [FIFO_DEPTH];
  logic [LEN_W-1:0]  fifo_len_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]    level_q;
  logic              push, pop;

  // Scheduler state
  state_e            state_q;
  logic [ADDR_W-1:0] cur_src_q, cur_dst_q;
  logic [LEN_W-1:0]  rem_q;
  logic [WD_W-1:0]   wd_q;
  logic [ADDR_W-1:0] dma_rd_addr_q, dma_wr_addr_q;
  logic [LEN_W-1:0]  dma_len_q;
  logic              dma_start_q;
  logic [31:0]       jobs_done_q, chunks_issued_q;
  logic              err_zero_len_q, err_timeout_q;

  // Position after the chunk just completed; addresses wrap modulo 2^ADDR_W.
  logic [LEN_W-1:0]  rem_d;
  logic [ADDR_W-1:0] src_d, dst_d;
  logic              drain_clear;

  function automatic logic [LEN_W-1:0] chunk_of(input logic [LEN_W-1:0] rem);
    return (rem > MAX_CHUNK_L) ? MAX_CHUNK_L : rem;
  endfunction

  assign desc_ready  = (level_q != FULL_LEVEL);
  assign push        = desc_valid && desc_ready;
  assign pop         = (state_q == S_IDLE) && (level_q != '0);
  assign rem_d       = rem_q - dma_len_q;
  assign src_d       = cur_src_q + ADDR_W'(dma_len_q);
  assign dst_d       = cur_dst_q + ADDR_W'(dma_len_q);
  assign drain_clear = !c0NotEmpty && !c1NotEmpty;

  // NOTE: queue storage has no reset; validity is tracked by the pointers and
  // level, so clearing the payload would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_src_q[wr_ptr_q] <= desc_src;
      fifo_dst_q[wr_ptr_q] <= desc_dst;
      fifo_len_q[wr_ptr_q] <= desc_len;
    end
  end

  // Pointers wrap naturally because FIFO_DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= S_IDLE;
      cur_src_q       <= '0;
      cur_dst_q       <= '0;
      rem_q           <= '0;
      wd_q            <= '0;
      dma_rd_addr_q   <= '0;
      dma_wr_addr_q   <= '0;
      dma_len_q       <= '0;
      dma_start_q     <= 1'b0;
      jobs_done_q     <= '0;
      chunks_issued_q <= '0;
      err_zero_len_q  <= 1'b0;
      err_timeout_q   <= 1'b0;
    end else begin
      dma_start_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (pop) begin
            cur_src_q <= fifo_src_q[rd_ptr_q];
            cur_dst_q <= fifo_dst_q[rd_ptr_q];
            rem_q     <= fifo_len_q[rd_ptr_q];
            state_q   <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (rem_q == '0) begin
            err_zero_len_q <= 1'b1;
            state_q        <= S_IDLE;
          end else begin
            // Start outputs are registered on entry so they are valid for the
            // whole ISSUE cycle.
            dma_rd_addr_q   <= cur_src_q;
            dma_wr_addr_q   <= cur_dst_q;
            dma_len_q       <= chunk_of(rem_q);
            dma_start_q     <= 1'b1;
            chunks_issued_q <= chunks_issued_q + 32'd1;
            state_q         <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          wd_q    <= '0;
          state_q <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          wd_q <= wd_q + 1'b1;
          // A done arriving in the expiry cycle takes priority over the timeout.
          if (dma_done) begin
            state_q <= S_DRAIN;
          end else if (wd_q == WD_LIMIT) begin
            err_timeout_q <= 1'b1;
            state_q       <= S_IDLE;
          end
        end
        S_DRAIN: begin
          if (drain_clear) begin
            rem_q     <= rem_d;
            cur_src_q <= src_d;
            cur_dst_q <= dst_d;
            if (rem_d == '0) begin
              jobs_done_q <= jobs_done_q + 32'd1;
              state_q     <= S_IDLE;
            end else begin
              dma_rd_addr_q   <= src_d;
              dma_wr_addr_q   <= dst_d;
              dma_len_q       <= chunk_of(rem_d);
              dma_start_q     <= 1'b1;
              chunks_issued_q <= chunks_issued_q + 32'd1;
              state_q         <= S_ISSUE;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
      // NOTE: the later non-blocking assignment wins, so placing the clear
      // after the FSM gives it priority over a coincident increment or set.
      if (clr_stats) begin
        jobs_done_q     <= '0;
        chunks_issued_q <= '0;
        err_zero_len_q  <= 1'b0;
        err_timeout_q   <= 1'b0;
      end
    end
  end

  assign dma_rd_addr   = dma_rd_addr_q;
  assign dma_wr_addr   = dma_wr_addr_q;
  assign dma_len       = dma_len_q;
  assign dma_start     = dma_start_q;
  assign idle          = (state_q == S_IDLE) && (level_q == '0);
  assign queue_level   = level_q;
  assign jobs_done     = jobs_done_q;
  assign chunks_issued = chunks_issued_q;
  assign err_zero_len  = err_zero_len_q;
  assign err_timeout   = err_timeout_q;

endmodule

// File: tb/tb_dma_job_sched.sv
// Testbench for dma_job_sched. Two instances: dut_a (MAX_CHUNK=256) and
// dut_b (MAX_CHUNK=2), both with TIMEOUT_CYCLES=16. A scoreboard queue per
// instance holds the expected engine starts; a monitor pops and compares on
// every dma_start.
module tb_dma_job_sched;

  localparam int ADDR_W = 42;
  localparam int LEN_W  = 32;

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [ADDR_W-1:0] wr;
    logic [LEN_W-1:0]  len;
  } chunk_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Shared stimulus
  logic [ADDR_W-1:0] desc_src, desc_dst;
  logic [LEN_W-1:0]  desc_len;
  logic              c0_ne, c1_ne, clr_stats;
  // Per-instance stimulus and observation
  logic              a_desc_valid, b_desc_valid, a_dma_done, b_dma_done;
  logic              a_desc_ready, b_desc_ready, a_dma_start, b_dma_start;
  logic [ADDR_W-1:0] a_rd, a_wr, b_rd, b_wr;
  logic [LEN_W-1:0]  a_len, b_len;
  logic              a_idle, b_idle, a_ezl, b_ezl, a_eto, b_eto;
  logic [2:0]        a_level, b_level;
  logic [31:0]       a_jobs, b_jobs, a_chunks, b_chunks;

  dma_job_sched #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .FIFO_DEPTH(4), .MAX_CHUNK(256),
                  .TIMEOUT_CYCLES(16)) dut_a (
    .clk(clk), .reset(reset), .desc_valid(a_desc_valid), .desc_ready(a_desc_ready),
    .desc_src(desc_src), .desc_dst(desc_dst), .desc_len(desc_len),
    .dma_rd_addr(a_rd), .dma_wr_addr(a_wr), .dma_len(a_len), .dma_start(a_dma_start),
    .dma_done(a_dma_done), .c0NotEmpty(c0_ne), .c1NotEmpty(c1_ne), .clr_stats(clr_stats),
    .idle(a_idle), .queue_level(a_level), .jobs_done(a_jobs), .chunks_issued(a_chunks),
    .err_zero_len(a_ezl), .err_timeout(a_eto));

  dma_job_sched #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .FIFO_DEPTH(4), .MAX_CHUNK(2),
                  .TIMEOUT_CYCLES(16)) dut_b (
    .clk(clk), .reset(reset), .desc_valid(b_desc_valid), .desc_ready(b_desc_ready),
    .desc_src(desc_src), .desc_dst(desc_dst), .desc_len(desc_len),
    .dma_rd_addr(b_rd), .dma_wr_addr(b_wr), .dma_len(b_len), .dma_start(b_dma_start),
    .dma_done(b_dma_done), .c0NotEmpty(c0_ne), .c1NotEmpty(c1_ne), .clr_stats(clr_stats),
    .idle(b_idle), .queue_level(b_level), .jobs_done(b_jobs), .chunks_issued(b_chunks),
    .err_zero_len(b_ezl), .err_timeout(b_eto));

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic fail_timeout(input string name);
    n_checks++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  // Scoreboard
  chunk_t      a_exp[$], b_exp[$];
  chunk_t      a_e, b_e;
  int          a_starts = 0, b_starts = 0;
  int unsigned a_last_start = 0, b_last_start = 0;

  task automatic expect_chunk(input bit to_b, input logic [ADDR_W-1:0] rd,
                              input logic [ADDR_W-1:0] wr, input logic [LEN_W-1:0] len);
    chunk_t c;
    c.rd = rd; c.wr = wr; c.len = len;
    if (to_b) b_exp.push_back(c);
    else a_exp.push_back(c);
  endtask

  always @(negedge clk) begin : monitor
    if (a_dma_start === 1'b1) begin
      a_starts++;
      a_last_start = cyc;
      if (a_exp.size() == 0) begin
        n_checks++;
        $display("FAIL a_start: unexpected start rd=0x%0h wr=0x%0h len=%0d", a_rd, a_wr, a_len);
      end else begin
        a_e = a_exp.pop_front();
        check("a_dma_rd_addr", a_rd, a_e.rd);
        check("a_dma_wr_addr", a_wr, a_e.wr);
        check("a_dma_len", a_len, a_e.len);
      end
    end
    if (b_dma_start === 1'b1) begin
      b_starts++;
      b_last_start = cyc;
      if (b_exp.size() == 0) begin
        n_checks++;
        $display("FAIL b_start: unexpected start rd=0x%0h wr=0x%0h len=%0d", b_rd, b_wr, b_len);
      end else begin
        b_e = b_exp.pop_front();
        check("b_dma_rd_addr", b_rd, b_e.rd);
        check("b_dma_wr_addr", b_wr, b_e.wr);
        check("b_dma_len", b_len, b_e.len);
      end
    end
  end

  // Engine models: dma_done pulses 5 cycles after each observed start.
  bit a_eng_en = 1'b1;
  int a_cd = 0, b_cd = 0;
  always @(negedge clk) begin : engines
    a_dma_done = 1'b0;
    b_dma_done = 1'b0;
    if (a_dma_start === 1'b1 && a_eng_en) a_cd = 5;
    else if (a_cd > 0) begin a_cd--; if (a_cd == 0) a_dma_done = 1'b1; end
    if (b_dma_start === 1'b1) b_cd = 5;
    else if (b_cd > 0) begin b_cd--; if (b_cd == 0) b_dma_done = 1'b1; end
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic push(input bit to_b, input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] d,
                      input logic [LEN_W-1:0] l, output int unsigned acc_cyc);
    int n = 0;
    desc_src = s; desc_dst = d; desc_len = l;
    if (to_b) b_desc_valid = 1'b1; else a_desc_valid = 1'b1;
    while ((to_b ? b_desc_ready : a_desc_ready) !== 1'b1 && n < 200) begin
      @(negedge clk); n++;
    end
    if (n >= 200) fail_timeout("push_ready");
    @(negedge clk);
    acc_cyc = cyc;
    a_desc_valid = 1'b0;
    b_desc_valid = 1'b0;
  endtask

  task automatic wait_idle(input bit to_b, input string name);
    int n = 0;
    while (!((to_b ? b_idle : a_idle) === 1'b1 &&
             (to_b ? b_exp.size() : a_exp.size()) == 0) && n < 3000) begin
      @(negedge clk); n++;
    end
    if (n >= 3000) fail_timeout(name);
  endtask

  task automatic wait_starts(input bit to_b, input int target, input string name);
    int n = 0;
    while ((to_b ? b_starts : a_starts) < target && n < 500) begin
      @(negedge clk); n++;
    end
    if (n >= 500) fail_timeout(name);
  endtask

  initial begin : global_bound
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    int unsigned acc, s, drop;
    int n;
    reset = 1'b1;
    a_desc_valid = 1'b0; b_desc_valid = 1'b0;
    desc_src = '0; desc_dst = '0; desc_len = '0;
    c0_ne = 1'b0; c1_ne = 1'b0; clr_stats = 1'b0;
    #1;
    check("rst_idle", a_idle, 1);
    check("rst_desc_ready", a_desc_ready, 1);
    check("rst_queue_level", a_level, 0);
    check("rst_dma_start", a_dma_start, 0);
    check("rst_jobs_done", a_jobs, 0);
    check("rst_err_flags", {a_ezl, a_eto}, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // T1: 600 lines in 256-line chunks; start 2 cycles after the accept edge.
    expect_chunk(0, 42'h100, 42'h200, 256);
    expect_chunk(0, 42'h200, 42'h300, 256);
    expect_chunk(0, 42'h300, 42'h400, 88);
    push(0, 42'h100, 42'h200, 600, acc);
    wait_starts(0, 1, "t1_first_start");
    check("t1_start_latency", a_last_start, acc + 2);
    wait_idle(0, "t1_idle");
    check("t1_jobs_done", a_jobs, 1);
    check("t1_chunks_issued", a_chunks, 3);
    check("t1_idle", a_idle, 1);

    // T2: five back-to-back descriptors; head is popped at the 2nd edge, so
    // all five are accepted and the level peaks at 4.
    expect_chunk(0, 42'h1000, 42'h2000, 3);
    expect_chunk(0, 42'h3000, 42'h4000, 256);
    expect_chunk(0, 42'h3100, 42'h4100, 44);
    expect_chunk(0, 42'h5000, 42'h6000, 1);
    expect_chunk(0, 42'h7000, 42'h8000, 256);
    expect_chunk(0, 42'h9000, 42'hA000, 256);
    expect_chunk(0, 42'h9100, 42'hA100, 1);
    for (int i = 0; i < 5; i++) begin
      desc_src = 42'h1000 + 42'(i) * 42'h2000;
      desc_dst = desc_src + 42'h1000;
      case (i)
        0: desc_len = 3;
        1: desc_len = 300;
        2: desc_len = 1;
        3: desc_len = 256;
        default: desc_len = 257;
      endcase
      a_desc_valid = 1'b1;
      check("t2_ready_before_accept", a_desc_ready, 1);
      @(negedge clk);
    end
    a_desc_valid = 1'b0;
    check("t2_ready_full", a_desc_ready, 0);
    check("t2_level_peak", a_level, 4);
    wait_idle(0, "t2_idle");
    check("t2_jobs_done", a_jobs, 6);
    check("t2_chunks_issued", a_chunks, 10);

    // T3: writes still in flight after the first chunk's done hold the next start.
    c1_ne = 1'b1;
    expect_chunk(0, 42'h20000, 42'h30000, 256);
    expect_chunk(0, 42'h20100, 42'h30100, 144);
    push(0, 42'h20000, 42'h30000, 400, acc);
    n = 0;
    @(posedge clk);
    while (a_dma_done !== 1'b1 && n < 100) begin @(posedge clk); n++; end
    if (n >= 100) fail_timeout("t3_done");
    repeat (20) @(negedge clk);
    check("t3_held_in_drain", a_starts, 11);
    c1_ne = 1'b0;
    drop = cyc;
    wait_starts(0, 12, "t3_second_start");
    // The first edge sampling c1NotEmpty low leaves DRAIN; ISSUE is the next cycle.
    check("t3_start_after_drain", a_last_start, drop + 1);
    wait_idle(0, "t3_idle");
    check("t3_jobs_done", a_jobs, 7);

    // T4: zero-length descriptor is discarded, next job runs.
    check("t4_err_zero_len_clear", a_ezl, 0);
    expect_chunk(0, 42'h60, 42'h70, 1);
    push(0, 42'h40, 42'h50, 0, acc);
    push(0, 42'h60, 42'h70, 1, acc);
    wait_idle(0, "t4_idle");
    check("t4_err_zero_len", a_ezl, 1);
    check("t4_jobs_done", a_jobs, 8);
    check("t4_chunks_issued", a_chunks, 13);

    // T5: engine silent for the first job -> watchdog; second job runs.
    a_eng_en = 1'b0;
    expect_chunk(0, 42'h500, 42'h600, 10);
    expect_chunk(0, 42'h700, 42'h800, 5);
    push(0, 42'h500, 42'h600, 10, acc);
    push(0, 42'h700, 42'h800, 5, acc);
    wait_starts(0, 14, "t5_first_start");
    s = a_last_start;
    // 16 WAIT_DONE cycles follow the start cycle; the flag rises at the edge after.
    while (cyc < s + 16) @(negedge clk);
    check("t5_err_timeout_early", a_eto, 0);
    @(negedge clk);
    check("t5_err_timeout", a_eto, 1);
    check("t5_jobs_not_counted", a_jobs, 8);
    a_eng_en = 1'b1;
    wait_idle(0, "t5_idle");
    check("t5_jobs_done", a_jobs, 9);
    check("t5_chunks_issued", a_chunks, 15);
    check("t5_err_timeout_sticky", a_eto, 1);

    // clr_stats coincides with the jobs_done increment (DRAIN exit edge).
    expect_chunk(0, 42'hB00, 42'hC00, 2);
    push(0, 42'hB00, 42'hC00, 2, acc);
    n = 0;
    @(posedge clk);
    while (a_dma_done !== 1'b1 && n < 100) begin @(posedge clk); n++; end
    if (n >= 100) fail_timeout("t5_clr_done");
    @(negedge clk);
    clr_stats = 1'b1;
    @(negedge clk);
    clr_stats = 1'b0;
    check("t5_clr_idle", a_idle, 1);
    check("t5_clr_jobs_done", a_jobs, 0);
    check("t5_clr_chunks", a_chunks, 0);
    check("t5_clr_errors", {a_ezl, a_eto}, 0);

    // T6: source address wraps at 2^42 on dut_b (2-line chunks).
    expect_chunk(1, 42'h3FF_FFFF_FFFE, 42'h10, 2);
    expect_chunk(1, 42'h0, 42'h12, 2);
    push(1, 42'h3FF_FFFF_FFFE, 42'h10, 4, acc);
    wait_idle(1, "t6_idle");
    check("t6_jobs_done", b_jobs, 1);
    check("t6_chunks_issued", b_chunks, 2);

    // Asynchronous reset while in WAIT_DONE: outputs clear with no clock edge.
    expect_chunk(1, 42'h5, 42'h6, 2);
    push(1, 42'h5, 42'h6, 4, acc);
    wait_starts(1, 3, "t6_reset_start");
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("t6_rst_dma_start", b_dma_start, 0);
    check("t6_rst_rd_addr", b_rd, 0);
    check("t6_rst_wr_addr", b_wr, 0);
    check("t6_rst_len", b_len, 0);
    check("t6_rst_counters", {b_jobs, b_chunks}, 0);
    check("t6_rst_idle", b_idle, 1);
    check("t6_rst_ready", b_desc_ready, 1);
    check("t6_rst_level", b_level, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    check("t6_post_rst_idle", b_idle, 1);
    check("t6_post_rst_no_start", b_chunks, 0);

    check("a_scoreboard_empty", a_exp.size(), 0);
    check("b_scoreboard_empty", b_exp.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
